// File: rtl/outport_sw_arbiter.sv
// rtl/outport_sw_arbiter.sv - per-output-port round-robin switch arbiter, packet-granular grant
// Optional idle-timeout release when ARB_TIMEOUT_EN is defined.
module outport_sw_arbiter #(
  parameter int NREQ    = 4,
  parameter int NVC     = 2,
  parameter int VCW     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*VCW-1:0] req_vch,
  input  logic [NREQ-1:0]   fvalid,
  input  logic [NREQ*2-1:0] ftype,
  input  logic [NVC-1:0]    ordy,
  input  logic [NVC-1:0]    olck,
  output logic [NREQ-1:0]   grant,
  output logic [VCW-1:0]    gvch,
  output logic              busy,
  output logic              err
);

  localparam int PW = $clog2(NREQ);
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("outport_sw_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] grant_nx;
  logic [VCW-1:0]  gvch_nx;
  logic            busy_nx, err_nx;
  logic [PW-1:0]   rr_ptr, rr_ptr_nx;
  logic [PW-1:0]   gidx, gidx_nx;
  logic            head_seen, head_seen_nx;

  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     cand;
  logic            g_valid;
  logic [1:0]      g_type;
  logic            err_ev, tail_ok, to_hit;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && ordy[req_vch[i*VCW +: VCW]] && !olck[req_vch[i*VCW +: VCW]];
    end
  end

  // First eligible index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!win_found && elig[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  assign g_valid = (state == HOLD) && fvalid[gidx];
  assign g_type  = ftype[2*gidx +: 2];
  assign tail_ok = g_valid && head_seen && (g_type == FT_TAIL);
  assign err_ev  = (|(fvalid & ~grant))
                 || (g_valid && head_seen && (g_type == FT_HEAD))
                 || (g_valid && !head_seen && ((g_type == FT_BODY) || (g_type == FT_TAIL)));

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt, idle_cnt_nx;

  assign to_hit = (state == HOLD) && !g_valid && (idle_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    idle_cnt_nx = idle_cnt;
    if (state == IDLE || g_valid) idle_cnt_nx = '0;
    else                          idle_cnt_nx = idle_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) idle_cnt <= '0;
    else      idle_cnt <= idle_cnt_nx;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    gvch_nx      = gvch;
    busy_nx      = busy;
    err_nx       = err | err_ev;
    rr_ptr_nx    = rr_ptr;
    gidx_nx      = gidx;
    head_seen_nx = head_seen;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nx          = '0;
          grant_nx[win_idx] = 1'b1;
          gvch_nx           = req_vch[win_idx*VCW +: VCW];
          busy_nx           = 1'b1;
          gidx_nx           = win_idx;
          head_seen_nx      = 1'b0;
          state_nx          = HOLD;
        end
      end
      HOLD: begin
        if (g_valid && !head_seen && (g_type == FT_HEAD)) head_seen_nx = 1'b1;
        if (tail_ok || to_hit) begin
          grant_nx     = '0;
          busy_nx      = 1'b0;
          head_seen_nx = 1'b0;
          rr_ptr_nx    = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state_nx     = IDLE;
        end
        if (to_hit) err_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state     <= IDLE;
      grant     <= '0;
      gvch      <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      rr_ptr    <= '0;
      gidx      <= '0;
      head_seen <= 1'b0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      gvch      <= gvch_nx;
      busy      <= busy_nx;
      err       <= err_nx;
      rr_ptr    <= rr_ptr_nx;
      gidx      <= gidx_nx;
      head_seen <= head_seen_nx;
    end
  end

endmodule

// File: tb/tb_outport_sw_arbiter.sv
// tb/tb_outport_sw_arbiter.sv - directed scoreboard bench for outport_sw_arbiter
module tb_outport_sw_arbiter;

  localparam int NREQ = 4;
  localparam int NVC  = 2;
  localparam int VCW  = 1;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              rst_;
  logic [NREQ-1:0]   req;
  logic [NREQ*VCW-1:0] req_vch;
  logic [NREQ-1:0]   fvalid;
  logic [NREQ*2-1:0] ftype;
  logic [NVC-1:0]    ordy;
  logic [NVC-1:0]    olck;
  logic [NREQ-1:0]   grant;
  logic [VCW-1:0]    gvch;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [NREQ-1:0] g; logic [VCW-1:0] v;} exp_t;
  exp_t sb[$];

  outport_sw_arbiter #(.NREQ(NREQ), .NVC(NVC), .VCW(VCW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_(rst_), .req(req), .req_vch(req_vch), .fvalid(fvalid),
    .ftype(ftype), .ordy(ordy), .olck(olck), .grant(grant), .gvch(gvch),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NREQ-1:0] g, input logic [VCW-1:0] v);
    exp_t e;
    e.g = g;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string tag, input int exp_lat);
    int n = 0;
    exp_t e;
    while (grant == '0 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_grant"}, grant, e.g);
      chk({tag, "_gvch"}, gvch, e.v);
      chk({tag, "_busy"}, busy, 1);
    end
  endtask

  task automatic flit(input int idx, input logic [1:0] t);
    fvalid = '0;
    fvalid[idx] = 1'b1;
    ftype[2*idx +: 2] = t;
    step();
    fvalid = '0;
  endtask

  task automatic send_packet(input string tag, input int idx, input int n);
    for (int f = 0; f < n; f++) begin
      if (f == 0)          flit(idx, 2'b01);
      else if (f == n - 1) flit(idx, 2'b11);
      else                 flit(idx, 2'b10);
    end
    chk({tag, "_rel_grant"}, grant, 0);
    chk({tag, "_rel_busy"}, busy, 0);
  endtask

  initial begin
    int order[5];
    order = '{1, 2, 3, 0, 1};
    rst_ = 1'b1; req = '0; req_vch = '0; fvalid = '0; ftype = '0; ordy = '0; olck = '0;
    step(); step();
    chk("rst_grant", grant, 0);
    chk("rst_gvch", gvch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_ = 1'b0;
    step();
    chk("idle_grant", grant, 0);

    // single requester, 4-flit packet
    req = 4'b0001; ordy = 2'b11;
    push_exp(4'b0001, 1'b0);
    wait_grant("t1", 1);
    req = '0;
    send_packet("t1", 0, 4);

    // all requesting: rotation starts after requester 0
    req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      push_exp(4'b0001 << order[p], 1'b0);
      wait_grant($sformatf("t2_%0d", p), 1);
      send_packet($sformatf("t2_%0d", p), order[p], 3);
    end
    req = '0;

    // requester 0's VC not ready, requester 1 on VC1 wins; grant frozen in HOLD
    req = 4'b0011; req_vch = 4'b0010; ordy = 2'b10;
    push_exp(4'b0010, 1'b1);
    wait_grant("t3", 1);
    ordy = 2'b11;
    step(); step();
    chk("t3_hold_grant", grant, 4'b0010);
    chk("t3_hold_gvch", gvch, 1);
    req = '0;
    send_packet("t3", 1, 3);

    // locked VC blocks, unlock grants next edge
    req = 4'b0100; req_vch = 4'b0100; olck = 2'b10;
    step(); step(); step();
    chk("t4_locked_grant", grant, 0);
    olck = 2'b00;
    push_exp(4'b0100, 1'b1);
    wait_grant("t4", 1);
    req = '0;
    flit(2, 2'b01);
    chk("t4_err_clean", err, 0);
    flit(3, 2'b01);
    chk("t5_err_set", err, 1);
    chk("t5_grant_kept", grant, 4'b0100);
    step();
    chk("t5_err_sticky", err, 1);
    flit(2, 2'b10);
    flit(2, 2'b11);
    chk("t5_rel_grant", grant, 0);

    // reset mid-packet drops grant asynchronously
    req = 4'b0001; req_vch = '0;
    push_exp(4'b0001, 1'b0);
    wait_grant("t6", 1);
    flit(0, 2'b01);
    rst_ = 1'b1;
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_err", err, 0);
    step();
    rst_ = 1'b0;

    // head then silence
    push_exp(4'b0001, 1'b0);
    wait_grant("t7", 1);
    flit(0, 2'b01);
`ifdef ARB_TIMEOUT_EN
    repeat (TO - 1) step();
    chk("t7_before_to", grant, 4'b0001);
    step();
    chk("t7_to_grant", grant, 0);
    chk("t7_to_busy", busy, 0);
    chk("t7_to_err", err, 1);
    req = 4'b0011;
    push_exp(4'b0010, 1'b0);
    wait_grant("t7_next", 1);
    req = '0;
    send_packet("t7_next", 1, 2);
`else
    repeat (120) step();
    chk("t7_held_grant", grant, 4'b0001);
    chk("t7_held_err", err, 0);
    req = '0;
    flit(0, 2'b11);
    chk("t7_rel_grant", grant, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
